// File: rtl/key_debouncer.sv
// key_debouncer: per-channel 2-flop synchroniser, stability-count debouncer
// and press/release one-shot generator for push-button inputs.
//
// state           | meaning
// ----------------|-------------------------------------------------------
// ST_IDLE         | key accepted as released, waiting for a pressed sample
// ST_PRESS_WAIT   | counting consecutive pressed samples toward acceptance
// ST_PRESSED      | key accepted as pressed, waiting for a released sample
// ST_RELEASE_WAIT | counting consecutive released samples toward acceptance
module key_debouncer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  logic [N-1:0]  w_p;
  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  state_t        r_state [N];
  logic [CW-1:0] r_cnt   [N];
  logic [N-1:0]  r_level;
  logic [N-1:0]  r_press;
  logic [N-1:0]  r_release;

  // Normalise polarity so that 1 always means "pressed".
  assign w_p = ACTIVE_LOW ? ~key_in : key_in;

  // Two-flop synchroniser; reset to the unpressed value.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_p;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel debounce FSM with registered level and one-cycle pulses.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_press[i]   <= 1'b0;
        r_release[i] <= 1'b0;
        case (r_state[i])
          ST_IDLE: begin
            if (r_sync2[i]) begin
              r_state[i] <= ST_PRESS_WAIT;
              r_cnt[i]   <= CW'(1);
            end
          end
          ST_PRESS_WAIT: begin
            if (!r_sync2[i]) begin
              // Bounce: discard the partial count entirely.
              r_state[i] <= ST_IDLE;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_state[i] <= ST_PRESSED;
              r_cnt[i]   <= '0;
              r_level[i] <= 1'b1;
              r_press[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end
          ST_PRESSED: begin
            if (!r_sync2[i]) begin
              r_state[i] <= ST_RELEASE_WAIT;
              r_cnt[i]   <= CW'(1);
            end
          end
          ST_RELEASE_WAIT: begin
            if (r_sync2[i]) begin
              r_state[i] <= ST_PRESSED;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_state[i]   <= ST_IDLE;
              r_cnt[i]     <= '0;
              r_level[i]   <= 1'b0;
              r_release[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end
          default: begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign key_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer: table-driven clean press/release, hand-written
// corner sequences, and randomized key activity checked against a run-length
// reference model (a change is accepted after D consecutive differing samples).
module tb_key_debouncer;

  localparam int N = 4;
  localparam int D = 4;

  logic         CLOCK_50;
  logic         resetn;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [N-1:0] m_h0, m_h1;
  logic [N-1:0] m_level, m_press, m_rel;
  int           m_run [N];

  typedef struct {
    logic [N-1:0] key;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t vecs [28];

  key_debouncer #(.N(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .key_in        (key_in),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_h0 = '0; m_h1 = '0;
    m_level = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
  endtask

  // One clock edge of the abstract model: the decision uses the sample that
  // has travelled through both synchroniser stages.
  task automatic model_step(input logic [N-1:0] k);
    logic s;
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < N; c++) begin
      s = m_h1[c];
      if (s != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_level[c] = s;
          if (s) m_press[c] = 1'b1;
          else   m_rel[c]   = 1'b1;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_h1 = m_h0;
    m_h0 = ~k;
  endtask

  // Drive keys, take one edge, then compare all outputs with the model.
  task automatic tick(input logic [N-1:0] k);
    key_in = k;
    @(posedge CLOCK_50);
    model_step(k);
    #1;
    chk("model_level", key_level, m_level);
    chk("model_press", press_pulse, m_press);
    chk("model_release", release_pulse, m_rel);
    chk("press_release_excl", press_pulse & release_pulse, '0);
  endtask

  function automatic logic bounce_low(input int t);
    return (t == 0 || t == 1 || t == 3 || t == 4 || t == 5 || t >= 7);
  endfunction

  initial begin
    int np, nr, nbad, pidx;
    logic [N-1:0] k;

    resetn = 1'b0;
    key_in = '1;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_level", key_level, '0);
    chk("reset_press", press_pulse, '0);
    chk("reset_release", release_pulse, '0);
    resetn = 1'b1;
    repeat (4) tick('1);

    // Scenario 1: clean press on key 0 at edge 0, release at edge 20.
    for (int i = 0; i < 28; i++) begin
      vecs[i].key = (i < 20) ? 4'b1110 : 4'b1111;
      vecs[i].lvl = (i >= 5 && i < 25) ? 4'b0001 : 4'b0000;
      vecs[i].prs = (i == 5)  ? 4'b0001 : 4'b0000;
      vecs[i].rel = (i == 25) ? 4'b0001 : 4'b0000;
    end
    for (int i = 0; i < 28; i++) begin
      tick(vecs[i].key);
      chk($sformatf("s1_level[%0d]", i), key_level, vecs[i].lvl);
      chk($sformatf("s1_press[%0d]", i), press_pulse, vecs[i].prs);
      chk($sformatf("s1_release[%0d]", i), release_pulse, vecs[i].rel);
    end
    repeat (4) tick('1);

    // Scenario 2: bounce on key 1; final stable low from t=7, pulse at t=12.
    for (int t = 0; t < 20; t++) begin
      k = 4'b1111;
      k[1] = ~bounce_low(t);
      tick(k);
      if (t < 12) begin
        chk("s2_bounce_level", {3'b0, key_level[1]}, 4'b0000);
        chk("s2_bounce_press", {3'b0, press_pulse[1]}, 4'b0000);
      end else if (t == 12) begin
        chk("s2_press_edge", press_pulse, 4'b0010);
      end else begin
        chk("s2_after_press", press_pulse, 4'b0000);
        chk("s2_after_level", {3'b0, key_level[1]}, 4'b0001);
      end
    end
    repeat (10) tick('1);

    // Scenario 3: hold key 2 for 1000 cycles.
    np = 0; nr = 0; nbad = 0;
    for (int t = 0; t < 1000; t++) begin
      tick(4'b1011);
      if (press_pulse[2]) np++;
      if (release_pulse[2]) nr++;
      if (t >= 5 && !key_level[2]) nbad++;
    end
    chk("s3_press_count", 4'(np), 4'd1);
    chk("s3_release_count", 4'(nr), 4'd0);
    chk("s3_level_drops", 4'(nbad), 4'd0);
    repeat (10) tick('1);

    // Scenario 4: all keys at once, then bounce key 3 alone.
    for (int t = 0; t < 10; t++) begin
      tick(4'b0000);
      if (t == 5) chk("s4_all_press", press_pulse, 4'b1111);
      if (t == 6) chk("s4_all_press_drop", press_pulse, 4'b0000);
    end
    for (int t = 0; t < 12; t++) begin
      tick((t < 2) ? 4'b1000 : 4'b0000);
      chk("s4_bounce3_level", key_level, 4'b1111);
      chk("s4_bounce3_press", press_pulse, 4'b0000);
      chk("s4_bounce3_release", release_pulse, 4'b0000);
    end
    repeat (12) tick('1);

    // Scenario 5: reset while key 0 is in PRESSED.
    repeat (10) tick(4'b1110);
    chk("s5_pre_level", key_level, 4'b0001);
    #3 resetn = 1'b0;
    #1;
    chk("s5_async_level", key_level, '0);
    chk("s5_async_press", press_pulse, '0);
    chk("s5_async_release", release_pulse, '0);
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("s5_held_level", key_level, '0);
    resetn = 1'b1;
    np = 0; nr = 0; pidx = -1;
    for (int t = 1; t <= 12; t++) begin
      tick(4'b1110);
      if (press_pulse[0]) begin np++; pidx = t; end
      if (release_pulse[0]) nr++;
    end
    chk("s5_press_count", 4'(np), 4'd1);
    chk("s5_press_in_window", 4'((pidx == 5 || pidx == 6) ? 1 : 0), 4'd1);
    chk("s5_release_count", 4'(nr), 4'd0);

    // Scenario 6: two-cycle release glitch from PRESSED.
    for (int t = 0; t < 17; t++) begin
      tick((t < 2) ? 4'b1111 : 4'b1110);
      chk("s6_level", {3'b0, key_level[0]}, 4'b0001);
      chk("s6_press", {3'b0, press_pulse[0]}, 4'b0000);
      chk("s6_release", {3'b0, release_pulse[0]}, 4'b0000);
    end
    repeat (10) tick('1);

    // Randomized key activity with occasional toggles, model-checked.
    k = '1;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 6) == 0) k[c] = ~k[c];
      tick(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
